// File: rtl/disp_pkg.sv
// Shared constants for the calculator display driver.
// Opcodes, blank pattern, segment bit order, digit-enable helper.
package disp_pkg;

  localparam logic [1:0] CMD_LOAD_DIG = 2'd0;
  localparam logic [1:0] CMD_LOAD_LED = 2'd1;
  localparam logic [1:0] CMD_BEEP     = 2'd2;
  localparam logic [1:0] CMD_SET_MASK = 2'd3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // SEG is declared [0:7]: index 0 is segment a, index 7 is dp.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low one-hot digit enable, SD[0] = leftmost digit.
  function automatic logic [0:3] sd_onehot(input logic [1:0] idx);
    logic [0:3] v;
    v      = 4'b1111;
    v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/disp_driver_hex7seg.sv
// Hex nibble to active-low 7-segment pattern (a..g, dp).
// Ports: i_nib nibble, i_dp dp enable, o_seg[0:7] active-low segments.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  output logic [0:7] o_seg
);

  logic [0:6] w_ag;

  always_comb begin
    w_ag = 7'b1111111;
    case (i_nib)
      4'h0: w_ag = 7'b0000001;
      4'h1: w_ag = 7'b1001111;
      4'h2: w_ag = 7'b0010010;
      4'h3: w_ag = 7'b0000110;
      4'h4: w_ag = 7'b1001100;
      4'h5: w_ag = 7'b0100100;
      4'h6: w_ag = 7'b0100000;
      4'h7: w_ag = 7'b0001111;
      4'h8: w_ag = 7'b0000000;
      4'h9: w_ag = 7'b0000100;
      4'hA: w_ag = 7'b0001000;
      4'hB: w_ag = 7'b1100000;
      4'hC: w_ag = 7'b0110001;
      4'hD: w_ag = 7'b1000010;
      4'hE: w_ag = 7'b0110000;
      4'hF: w_ag = 7'b0111000;
      default: w_ag = 7'b1111111;
    endcase
  end

  always_comb begin
    o_seg         = {w_ag, 1'b1};
    o_seg[SEG_DP] = ~i_dp;
  end

endmodule

// File: rtl/disp_driver.sv
// Display driver: CPU commands -> muxed 4-digit 7-seg, LEDs, buzzer.
// Ports: Clock, Reset (sync, high), cmd_valid/cmd_ready/cmd/data,
//   SD[0:3] digit enables (low), SEG[0:7] a..dp (low), LD, Buzz.
// Define DISP_BUZZ_EN to build the beep/tone logic; else Buzz = 0.
module disp_driver
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int TONE_DIV  = 12500,
  parameter int BEEP_TICK = 500000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd,
  input  logic [15:0] data,
  output logic [0:3]  SD,
  output logic [0:7]  SEG,
  output logic [7:0]  LD,
  output logic        Buzz
);

  localparam int DW = $clog2(SCAN_DIV);

  logic          r_ready;
  logic [7:0]    r_ld;
  logic [15:0]   r_dig;
  logic [3:0]    r_mask;
  logic [3:0]    r_dp;
  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [0:3]    r_sd;
  logic [0:7]    r_seg;

  logic          w_acc;
  logic [3:0]    w_nib;
  logic [0:7]    w_hex;
  logic [0:7]    w_seg;

  assign w_acc = cmd_valid & r_ready;

  always_comb begin
    w_nib = 4'h0;
    case (r_idx)
      2'd0: w_nib = r_dig[15:12];
      2'd1: w_nib = r_dig[11:8];
      2'd2: w_nib = r_dig[7:4];
      2'd3: w_nib = r_dig[3:0];
      default: w_nib = 4'h0;
    endcase
  end

  hex7seg u_hex (
    .i_nib (w_nib),
    .i_dp  (r_dp[r_idx]),
    .o_seg (w_hex)
  );

  assign w_seg = r_mask[r_idx] ? SEG_BLANK : w_hex;

  // SD and SEG are registered from the same index so they switch together.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ready <= 1'b0;
      r_ld    <= '0;
      r_dig   <= '0;
      r_mask  <= 4'b1111;
      r_dp    <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_sd    <= 4'b1111;
      r_seg   <= SEG_BLANK;
    end else begin
      r_ready <= ~w_acc;
      if (r_div == DW'(SCAN_DIV - 1)) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_sd  <= sd_onehot(r_idx);
      r_seg <= w_seg;
      if (w_acc) begin
        case (cmd)
          CMD_LOAD_DIG: r_dig <= data;
          CMD_LOAD_LED: r_ld  <= data[7:0];
          CMD_SET_MASK: begin
            r_mask <= data[3:0];
            r_dp   <= data[7:4];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DISP_BUZZ_EN
  localparam int BW = $clog2(255 * BEEP_TICK + 1);
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [BW-1:0] r_beep;
  logic [TW-1:0] r_tone;
  logic          r_buzz;

  // A new BEEP restarts both duration and tone phase.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_beep <= '0;
      r_tone <= '0;
      r_buzz <= 1'b0;
    end else if (w_acc && cmd == CMD_BEEP) begin
      r_beep <= BW'(data[7:0]) * BW'(BEEP_TICK);
      r_tone <= '0;
      r_buzz <= 1'b0;
    end else if (r_beep != '0) begin
      r_beep <= r_beep - 1'b1;
      if (r_beep == BW'(1)) begin
        r_tone <= '0;
        r_buzz <= 1'b0;
      end else if (r_tone == TW'(TONE_DIV - 1)) begin
        r_tone <= '0;
        r_buzz <= ~r_buzz;
      end else begin
        r_tone <= r_tone + 1'b1;
      end
    end
  end

  assign Buzz = r_buzz;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TONE_DIV, BEEP_TICK};
  assign Buzz = 1'b0;
`endif

  assign cmd_ready = r_ready;
  assign LD        = r_ld;
  assign SD        = r_sd;
  assign SEG       = r_seg;

endmodule

// File: tb/tb_disp_driver.sv
// Randomized bench for disp_driver against a frame-position model.
// Outputs are checked every cycle, 1 time unit after the rising edge.
module tb_disp_driver;

  localparam int S  = 4;
  localparam int TD = 2;
  localparam int BT = 10;

  localparam logic [1:0] OP_DIG  = 2'd0;
  localparam logic [1:0] OP_LED  = 2'd1;
  localparam logic [1:0] OP_BEEP = 2'd2;
  localparam logic [1:0] OP_MASK = 2'd3;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd = 2'd0;
  logic [15:0] data = 16'h0;
  logic [0:3]  SD;
  logic [0:7]  SEG;
  logic [7:0]  LD;
  logic        Buzz;

  int total = 0;
  int bad   = 0;
  bit running = 1'b0;

  always #5 clk = ~clk;

  disp_driver #(
    .SCAN_DIV  (S),
    .TONE_DIV  (TD),
    .BEEP_TICK (BT)
  ) dut (
    .Clock     (clk),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .data      (data),
    .SD        (SD),
    .SEG       (SEG),
    .LD        (LD),
    .Buzz      (Buzz)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Active-low a..g patterns for hex digits, a in bit 6.
  logic [6:0] HX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model state: register contents plus edges since reset release.
  logic        m_ready, m_acc;
  logic [7:0]  m_ld;
  logic [15:0] m_dig;
  logic [3:0]  m_mask, m_dp;
  int          k, bstart, blen;
  logic [3:0]  e_sd;
  logic [7:0]  e_seg;
  logic        e_buzz;

  always @(posedge clk) begin : model
    int         idx, j;
    logic       acc;
    logic [3:0] tsd;
    logic [3:0] nib;
    if (Reset) begin
      m_ready <= 1'b0;
      m_acc   <= 1'b0;
      m_ld    <= 8'h00;
      m_dig   <= 16'h0;
      m_mask  <= 4'hF;
      m_dp    <= 4'h0;
      k       <= 0;
      bstart  <= 0;
      blen    <= 0;
      e_sd    <= 4'hF;
      e_seg   <= 8'hFF;
      e_buzz  <= 1'b0;
    end else begin
      // Digit lit during frame position k is floor(k/S) mod 4.
      idx = (k / S) % 4;
      tsd = 4'hF;
      tsd[3 - idx] = 1'b0;
      e_sd <= tsd;
      nib = m_dig[(3 - idx) * 4 +: 4];
      if (m_mask[idx]) e_seg <= 8'hFF;
      else e_seg <= {HX[nib], ~m_dp[idx]};
      k <= k + 1;
      acc = cmd_valid && m_ready;
      m_acc   <= acc;
      m_ready <= !acc;
      if (acc) begin
        case (cmd)
          OP_DIG:  m_dig <= data;
          OP_LED:  m_ld  <= data[7:0];
          OP_MASK: begin
            m_mask <= data[3:0];
            m_dp   <= data[7:4];
          end
          default: ;
        endcase
      end
      if (acc && cmd == OP_BEEP) begin
        bstart <= k + 1;
        blen   <= int'(data[7:0]) * BT;
        e_buzz <= 1'b0;
      end else begin
        j = k + 1 - bstart;
        e_buzz <= (j < blen) ? (((j / TD) % 2) == 1) : 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (running) begin
      #1;
      chk("sd", 16'(SD), 16'(e_sd));
      chk("seg", 16'(SEG), 16'(e_seg));
      chk("ld", 16'(LD), 16'(m_ld));
      chk("ready", 16'(cmd_ready), 16'(m_ready));
`ifdef DISP_BUZZ_EN
      chk("buzz", 16'(Buzz), 16'(e_buzz));
`else
      chk("buzz", 16'(Buzz), 16'h0);
`endif
    end
  end

  task automatic send(input logic [1:0] c, input logic [15:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    data      = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) got = 1'b1;
    end
    if (!got) chk("hs_timeout", 16'h0, 16'h1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Command held at the pins during reset must be dropped.
  task automatic do_reset(input int n);
    @(negedge clk);
    Reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd       = OP_LED;
    data      = 16'h00FF;
    repeat (n) @(negedge clk);
    Reset     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    running = 1'b1;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    idle(3);

    send(OP_DIG, 16'h08AF);
    send(OP_MASK, 16'h0000);
    idle(17);

    send(OP_MASK, 16'h0024);
    idle(17);

    send(OP_LED, 16'h0011);
    send(OP_LED, 16'h0022);
    idle(2);

    send(OP_BEEP, 16'h0003);
    idle(18);
    send(OP_BEEP, 16'h0003);
    idle(35);
    send(OP_BEEP, 16'h0003);
    idle(6);
    send(OP_BEEP, 16'h0000);
    idle(5);

    send(OP_BEEP, 16'h0003);
    idle(7);
    do_reset(2);
    idle(40);

    for (int it = 0; it < 250; it++) begin
      logic [1:0]  c;
      logic [15:0] d;
      if ($urandom_range(0, 39) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        c = 2'($urandom);
        d = 16'($urandom);
        if (c == OP_BEEP) d[7:0] = 8'($urandom_range(0, 4));
        send(c, d);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 6));
      end
    end
    idle(60);

    running = 1'b0;
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_driver.md
# disp_driver

Output-side driver for the calculator board. It is the display counterpart of the keypad scanner: it accepts display commands from the CPU over a valid/ready handshake and holds them in registers. From those registers it drives the time-multiplexed 4-digit 7-segment display, the 8 status LEDs and the buzzer. It sits between `CPU` and the board pins `SD`, `SEG`, `LD` and `Buzz`.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles each digit is lit; must be ≥ 2.
- `TONE_DIV`, 12500: clock cycles per buzzer half-period.
- `BEEP_TICK`, 500000: clock cycles per beep-duration unit.

Ports:
- `Clock` in 1: single clock for the whole block.
- `Reset` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd` in 2: opcode.
- `data` in 16: operand.
- `SD` out [0:3]: digit enables, active-low; `SD[0]` is the leftmost digit.
- `SEG` out [0:7]: segments a,b,c,d,e,f,g,dp, active-low.
- `LD` out 8: LEDs, active-high.
- `Buzz` out 1: buzzer drive.

## Operation
- **Handshake.** A command is accepted on a rising edge where `cmd_valid && cmd_ready`. After an accept, `cmd_ready` is low for exactly one cycle and then returns high. The maximum rate is therefore one command per 2 cycles. The CPU holds `cmd` and `data` stable while `cmd_valid` is high and `cmd_ready` is low.
- **Opcodes:**
  - 0 `LOAD_DIG`: the digit register takes `data`. `data[15:12]` goes to digit 0 and `data[3:0]` to digit 3.
  - 1 `LOAD_LED`: `LD` takes `data[7:0]`.
  - 2 `BEEP`: the beep counter takes `data[7:0]` × `BEEP_TICK`. A value of 0 silences the buzzer immediately. A `BEEP` issued while a beep is active restarts the duration and does not add to it.
  - 3 `SET_MASK`: `data[3:0]` is the blank mask (bit i = 1 blanks digit i). `data[7:4]` is the decimal-point enables (bit 4+i lights the dp of digit i).
- **Scan.** A divider counts 0..`SCAN_DIV`−1. At its terminal count the digit index advances 0→1→2→3→0 (wrap).
  - `SD` is one-hot-low on the current index.
  - A blanked digit drives `SEG` = 8'hFF, but its `SD` bit is still low.
- **Hex decode**, active-low, bit order a..dp. Examples: 0 → 00000011, 8 → 00000001, A → 00010001, F → 01110001. dp = 0 when enabled.
- **Buzzer.** While the beep counter is nonzero, `Buzz` toggles every `TONE_DIV` cycles. When the counter is zero, `Buzz` = 0. Counter decrement saturates at 0.
- **Reset.** While `Reset` is high, outputs are held at:
  - `SD` = 4'b1111, `SEG` = 8'hFF, `LD` = 0, `Buzz` = 0, `cmd_ready` = 0.
  - Internal state: digits 0, blank mask 4'b1111 (display dark), dp 0, all counters 0, index 0.
  - `cmd_ready` goes to 1 on the first edge with `Reset` low.
  - A reset asserted mid-beep or mid-scan aborts immediately. Commands presented during reset are dropped.

## Timing
- `LD` changes on the accept edge itself.
- `SD` and `SEG` are registered together, so a digit switch is glitch-free. They reflect a `LOAD_DIG` or `SET_MASK` one edge after the accept.
- A beep lasts `data[7:0]`×`BEEP_TICK` cycles, ±1 cycle, measured from the accept edge. The first `Buzz` rise occurs `TONE_DIV` cycles after the accept.
- Each digit is lit for exactly `SCAN_DIV` cycles. The full frame is 4×`SCAN_DIV` cycles.

## Configuration
- `DISP_BUZZ_EN` defined: the buzzer logic is present, as described above.
- `DISP_BUZZ_EN` undefined: the beep and tone counters are not built and `Buzz` is tied to 0. `BEEP` is still accepted with the normal handshake and has no effect.

## Structure
- Package `disp_pkg` holds:
  - the opcode constants `CMD_LOAD_DIG`, `CMD_LOAD_LED`, `CMD_BEEP`, `CMD_SET_MASK`;
  - `SEG_BLANK` = 8'hFF;
  - the segment bit-order definition.
- One sub-module, `hex7seg`: combinational, 4-bit nibble plus dp enable in, 8-bit active-low `SEG` out.

## Test plan
- **Reset:** hold `Reset` 3 cycles, then release. `SD`=1111, `SEG`=FF, `LD`=00 and `Buzz`=0 during reset. `cmd_ready` is 1 one cycle after release.
- **Digits:** `LOAD_DIG` 16'h08AF, then `SET_MASK` 8'h00, with `SCAN_DIV`=4. Over 16 cycles `SD`/`SEG` step through:
  - 0111/00000011,
  - 1011/00000001,
  - 1101/00010001,
  - 1110/01110001,
  - then wrap back to 0111.
- **Mask/dp:** `SET_MASK` 8'h24. Digit 2 shows `SEG`=FF and digit 1 has its dp bit = 0.
- **Handshake:** `cmd_valid` held high for 4 cycles with a `LOAD_LED` command. The ready pattern is 1,0,1,0, giving exactly 2 accepts. `LD` follows each `data[7:0]` on its accept edge.
- **Beep:** with `TONE_DIV`=2 and `BEEP_TICK`=10, send `BEEP` 3 and expect 30 cycles of toggling followed by `Buzz`=0.
  - Re-issuing `BEEP` 3 at cycle 20 extends the beep to cycle 50.
  - `BEEP` 0 stops it at once.
- **Reset mid-op:** assert `Reset` during a beep and a scan. `Buzz`=0 and the display is dark on the next edge, and no stale beep resumes after release.
